alu_muldiv_ctrl: RTL and testbench
==================================

# alu_muldiv_ctrl

Parametrised successor to the single-cycle ALU control path. It decodes ALUOp/Funct into the existing 5-bit ALU control codes and computes single-cycle results combinationally. It adds a multi-cycle iterative multiply/divide sequencer with HI/LO registers and a busy/stall handshake. It sits in the execute stage between the main decoder and the register-file write-back mux.

## Interface
- WIDTH, 32: datapath width; even, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  instruction valid this cycle.
- ALUOp  in  4  main-decoder op; bit 3 = unsigned flag for non-R ops.
- Funct  in  6  R-type function field.
- in1  in  WIDTH  operand A; in1[SHW-1:0] is the shift amount for shifts.
- in2  in  WIDTH  operand B; value shifted for shifts.
- result  out  WIDTH  combinational result.
- zero  out  1  result == 0.
- Sign  out  1  ALUOp[2:0]==3'b010 ? ~Funct[0] : ~ALUOp[3].
- busy  out  1  mul/div in progress; upstream must stall.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi, lo  out  WIDTH  HI/LO registers.

## Operation
- ALUCtl codes: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001.
- ALUOp[2:0] mapping: 000 ADD, 001 SUB, 100 AND, 101 SLT, 010 Funct-decode, others ADD.
- Funct mapping:
  - 00 SLL, 02 SRL, 03 SRA.
  - 20/21 ADD, 22/23 SUB.
  - 24 AND, 25 OR, 26 XOR, 27 NOR.
  - 2A/2B SLT; Sign selects signed or unsigned compare.
  - Unlisted Funct values decode to ADD.
- SLT result is zero-extended 0/1. Adds and subtracts wrap modulo 2^WIDTH; there is no overflow trap.
- Multi-cycle ops (ALUOp[2:0]==010 only): 18 MULT, 19 MULTU, 1A DIV, 1B DIVU.
- HI/LO access: 10 MFHI (result=hi), 12 MFLO (result=lo), 11 MTHI (hi←in1), 13 MTLO (lo←in1).
  - MTHI/MTLO write at the clock edge where start=1 and busy=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL or DIV on start·mul/div·!busy. Operands are latched as magnitudes (signed ops); the result sign and remainder sign are latched at the same time.
  - MUL/DIV: one radix-2 shift-add or restoring-subtract step per cycle, WIDTH steps. MUL→FIX and DIV→FIX after step WIDTH.
  - FIX: apply sign correction, write {hi,lo}, pulse done, →IDLE.
- Product: {hi,lo} = full 2·WIDTH-bit product.
- Quotient/remainder: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero: full latency; hi = original in1, lo = all ones.
- Signed MIN/−1: lo = MIN, hi = 0.
- start while busy is ignored: no FSM change and no MT write.
- result/zero always reflect the current inputs. During busy they are don't-care to upstream.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0, state IDLE. result/zero/Sign are combinational.
- Single-cycle ops: 0 latency, combinational.
- Mul/div: start sampled at edge E0. busy=1 from E0 until edge E(WIDTH+1). At E(WIDTH+1), hi/lo update, busy falls and done=1 for exactly one cycle. Total is WIDTH+1 cycles (33 at WIDTH=32).
- A new mul/div start is accepted in the cycle done=1, since busy=0 then.
- MFHI/MFLO in the cycle done=1 returns the new hi/lo.
- Reset asserted mid-operation aborts immediately: busy 0, hi/lo 0, no done pulse.

## Configuration
- ALU_MULDIV_EN defined: FSM, busy and done as above.
- ALU_MULDIV_EN undefined:
  - Funct 18–1B decode as ADD.
  - FSM removed; busy and done tied 0.
  - HI/LO registers and MF/MT ops remain.

## Test plan
- ALUOp=010, Funct=2A, in1=0xFFFFFFFF, in2=1 → result=1, Sign=1. Same with Funct=2B → result=0, Sign=0. ALUOp=001, in1=in2=5 → zero=1.
- MULT in1=0xFFFFFFFD (−3), in2=7 → busy for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU in1=in2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV in1=−7, in2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU in1=0x12345678, in2=0 → hi=0x12345678, lo=0xFFFFFFFF.
- Start MTLO 0xAA while busy → lo unchanged. After done, MTLO 0xAA then MFLO → result=0x000000AA.
- Assert reset at cycle 10 of a DIV → busy=0, hi=lo=0 immediately, no done. A following MULT 3×4 → lo=12, hi=0.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: execute-stage ALU control decode, combinational ALU and HI/LO registers.
// Define ALU_MULDIV_EN to add the iterative multiply/divide sequencer that drives busy/done.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] CTL_AND = 5'b00000;
  localparam logic [4:0] CTL_OR  = 5'b00001;
  localparam logic [4:0] CTL_ADD = 5'b00010;
  localparam logic [4:0] CTL_SUB = 5'b00110;
  localparam logic [4:0] CTL_SLT = 5'b00111;
  localparam logic [4:0] CTL_NOR = 5'b01100;
  localparam logic [4:0] CTL_XOR = 5'b01101;
  localparam logic [4:0] CTL_SLL = 5'b10000;
  localparam logic [4:0] CTL_SRL = 5'b11000;
  localparam logic [4:0] CTL_SRA = 5'b11001;

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  logic             is_r;
  logic [4:0]       alu_ctl;
  logic [SHW-1:0]   shamt;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_out;
  logic             mt_ok;
  logic             fix_wr;
  logic [WIDTH-1:0] hi_new;
  logic [WIDTH-1:0] lo_new;

  assign is_r  = (ALUOp[2:0] == 3'b010);
  assign Sign  = is_r ? ~Funct[0] : ~ALUOp[3];
  assign shamt = in1[SHW-1:0];

  always_comb begin
    alu_ctl = CTL_ADD;
    case (ALUOp[2:0])
      3'b001: alu_ctl = CTL_SUB;
      3'b100: alu_ctl = CTL_AND;
      3'b101: alu_ctl = CTL_SLT;
      3'b010: begin
        case (Funct)
          6'h00:        alu_ctl = CTL_SLL;
          6'h02:        alu_ctl = CTL_SRL;
          6'h03:        alu_ctl = CTL_SRA;
          6'h20, 6'h21: alu_ctl = CTL_ADD;
          6'h22, 6'h23: alu_ctl = CTL_SUB;
          6'h24:        alu_ctl = CTL_AND;
          6'h25:        alu_ctl = CTL_OR;
          6'h26:        alu_ctl = CTL_XOR;
          6'h27:        alu_ctl = CTL_NOR;
          6'h2A, 6'h2B: alu_ctl = CTL_SLT;
          default:      alu_ctl = CTL_ADD;
        endcase
      end
      default: alu_ctl = CTL_ADD;
    endcase
  end

  assign slt_bit = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

  always_comb begin
    alu_out = in1 + in2;
    case (alu_ctl)
      CTL_AND: alu_out = in1 & in2;
      CTL_OR:  alu_out = in1 | in2;
      CTL_ADD: alu_out = in1 + in2;
      CTL_SUB: alu_out = in1 - in2;
      CTL_SLT: alu_out = {{(WIDTH-1){1'b0}}, slt_bit};
      CTL_NOR: alu_out = ~(in1 | in2);
      CTL_XOR: alu_out = in1 ^ in2;
      CTL_SLL: alu_out = in2 << shamt;
      CTL_SRL: alu_out = in2 >> shamt;
      CTL_SRA: alu_out = $unsigned($signed(in2) >>> shamt);
      default: alu_out = in1 + in2;
    endcase
  end

  always_comb begin
    result = alu_out;
    if (is_r && Funct == F_MFHI)
      result = hi;
    else if (is_r && Funct == F_MFLO)
      result = lo;
  end

  assign zero  = (result == '0);
  assign mt_ok = start && !busy && is_r;

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state;
  logic [SHW-1:0]     step;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lsr;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH-1:0]   orig_a;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic               is_div;
  logic               muldiv_go;
  logic               last_step;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy      = (state != S_IDLE);
  assign muldiv_go = start && is_r && (state == S_IDLE) && (Funct[5:2] == 4'b0110);
  assign last_step = (step == SHW'(WIDTH-1));

  // Signed ops iterate on magnitudes; the signs are restored in FIX.
  assign a_neg = Sign && in1[WIDTH-1];
  assign b_neg = Sign && in2[WIDTH-1];
  assign a_mag = a_neg ? (~in1 + 1'b1) : in1;
  assign b_mag = b_neg ? (~in2 + 1'b1) : in2;

  assign mul_sum  = {1'b0, acc} + (lsr[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
  assign rem_sh   = {acc, lsr[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, bmag});
  assign rem_diff = rem_sh[WIDTH-1:0] - bmag;

  assign prod     = {acc, lsr};
  assign prod_fix = neg_res ? (~prod + 1'b1) : prod;
  assign quot_fix = neg_res ? (~lsr + 1'b1) : lsr;
  assign rem_fix  = neg_rem ? (~acc + 1'b1) : acc;

  assign fix_wr = (state == S_FIX);
  assign hi_new = is_div ? (div0 ? orig_a : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_new = is_div ? (div0 ? {WIDTH{1'b1}} : quot_fix) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      step    <= '0;
      acc     <= '0;
      lsr     <= '0;
      bmag    <= '0;
      orig_a  <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      is_div  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (muldiv_go) begin
            state   <= Funct[1] ? S_DIV : S_MUL;
            is_div  <= Funct[1];
            step    <= '0;
            acc     <= '0;
            lsr     <= a_mag;
            bmag    <= b_mag;
            orig_a  <= in1;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (in2 == '0);
          end
        end
        S_MUL: begin
          {acc, lsr} <= {mul_sum, lsr[WIDTH-1:1]};
          step       <= step + 1'b1;
          if (last_step)
            state <= S_FIX;
        end
        S_DIV: begin
          acc  <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          lsr  <= {lsr[WIDTH-2:0], rem_ge};
          step <= step + 1'b1;
          if (last_step)
            state <= S_FIX;
        end
        S_FIX: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign busy   = 1'b0;
  assign done   = 1'b0;
  assign fix_wr = 1'b0;
  assign hi_new = '0;
  assign lo_new = '0;
`endif

  // FIX and MT writes never collide: busy is high throughout FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      hi <= hi_new;
      lo <= lo_new;
    end else if (mt_ok) begin
      if (Funct == F_MTHI)
        hi <= in1;
      if (Funct == F_MTLO)
        lo <= in1;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed self-checking bench with a scoreboard queue of expected outputs.
// Mul/div sequencing is exercised when ALU_MULDIV_EN is defined, otherwise the ADD fallback is.
module tb_alu_muldiv_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       ALUOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             Sign;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct(Funct),
    .in1(in1), .in2(in2), .result(result), .zero(zero), .Sign(Sign),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic [3:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    start = s;
    ALUOp = op;
    Funct = fn;
    in1   = a;
    in2   = b;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return result;
      1:       return {31'b0, zero};
      2:       return {31'b0, Sign};
      3:       return hi;
      4:       return lo;
      5:       return {31'b0, busy};
      6:       return {31'b0, done};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    compare(e.tag, observe(e.sel), e.exp);
  endtask

  task automatic check_all();
    while (sb.size() > 0)
      checkOutput();
  endtask

  function automatic logic [31:0] ref_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h26:        return a ^ b;
      6'h27:        return ~(a | b);
      default:      return a + b;
    endcase
  endfunction

`ifdef ALU_MULDIV_EN
  task automatic run_muldiv(input string tag, input logic [5:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cycles;
    int n;
    applyStimulus(1'b1, 4'b0010, fn, a, b);
    expect_val({tag, "_hi"}, 3, eh);
    expect_val({tag, "_lo"}, 4, el);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h20, 32'h0, 32'h0);
    compare({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
    compare({tag, "_done_e0"}, {31'b0, done}, 32'd0);
    cycles = 0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1)
        cycles++;
      n++;
      @(negedge clk);
    end
    compare({tag, "_done"}, {31'b0, done}, 32'd1);
    compare({tag, "_cycles"}, cycles, WIDTH + 1);
    check_all();
    applyStimulus(1'b0, 4'b0010, 6'h10, 32'h0, 32'h0);
    #1;
    compare({tag, "_mfhi_done"}, result, eh);
  endtask
`endif

  initial begin
    int n;
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;

    reset = 1'b0;
    applyStimulus(1'b0, 4'b0000, 6'h00, 32'h0, 32'h0);
    #1 reset = 1'b1;
    #2;
    expect_val("rst_busy", 5, 32'd0);
    expect_val("rst_done", 6, 32'd0);
    expect_val("rst_hi", 3, 32'd0);
    expect_val("rst_lo", 4, 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 4'b0010, 6'h2A, 32'hFFFF_FFFF, 32'h1);
    expect_val("slt_signed", 0, 32'd1);
    expect_val("slt_signed_sign", 2, 32'd1);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h2B, 32'hFFFF_FFFF, 32'h1);
    expect_val("sltu", 0, 32'd0);
    expect_val("sltu_sign", 2, 32'd0);
    #1 check_all();
    applyStimulus(1'b0, 4'b0001, 6'h00, 32'd5, 32'd5);
    expect_val("sub_zero", 1, 32'd1);
    expect_val("sub_res", 0, 32'd0);
    #1 check_all();
    applyStimulus(1'b0, 4'b1101, 6'h00, 32'hFFFF_FFFF, 32'h1);
    expect_val("slti_u", 0, 32'd0);
    expect_val("slti_u_sign", 2, 32'd0);
    #1 check_all();
    applyStimulus(1'b0, 4'b0101, 6'h00, 32'hFFFF_FFFF, 32'h1);
    expect_val("slti_s", 0, 32'd1);
    #1 check_all();
    applyStimulus(1'b0, 4'b0000, 6'h00, 32'hFFFF_FFFF, 32'h1);
    expect_val("add_wrap", 0, 32'd0);
    expect_val("add_wrap_zero", 1, 32'd1);
    #1 check_all();
    applyStimulus(1'b0, 4'b0100, 6'h00, 32'hF0F0_1234, 32'h0FF0_FF00);
    expect_val("andi", 0, 32'h00F0_1200);
    #1 check_all();
    applyStimulus(1'b0, 4'b0011, 6'h00, 32'd40, 32'd2);
    expect_val("op011_add", 0, 32'd42);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h00, 32'h0000_0124, 32'h1);
    expect_val("sll_mask", 0, 32'h10);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h03, 32'd31, 32'h8000_0000);
    expect_val("sra", 0, 32'hFFFF_FFFF);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h02, 32'd31, 32'h8000_0000);
    expect_val("srl", 0, 32'h1);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h3F, 32'd7, 32'd8);
    expect_val("unlisted_add", 0, 32'd15);
    #1 check_all();
    for (int i = 0; i < 8; i++) begin
      fn = 6'h20 + 6'(i);
      a  = $urandom;
      b  = $urandom;
      applyStimulus(1'b0, 4'b0010, fn, a, b);
      expect_val($sformatf("rtype_%0h", fn), 0, ref_r(fn, a, b));
      #1 check_all();
    end

    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h11, 32'h1234, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h10, 32'h0, 32'h0);
    expect_val("mfhi", 0, 32'h1234);
    expect_val("mthi_hi", 3, 32'h1234);
    #1 check_all();
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h13, 32'h5678, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h12, 32'h0, 32'h0);
    expect_val("mflo", 0, 32'h5678);
    #1 check_all();
    applyStimulus(1'b0, 4'b0010, 6'h13, 32'hDEAD, 32'h0);
    @(negedge clk);
    expect_val("mtlo_nostart", 4, 32'h5678);
    check_all();

`ifdef ALU_MULDIV_EN
    run_muldiv("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_muldiv("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run_muldiv("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_muldiv("div_min", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_muldiv("div_s0", 6'h1A, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h1B, 32'h1234_5678, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h13, 32'hAA, 32'h0);
    @(negedge clk);
    expect_val("mtlo_busy_lo", 4, 32'hFFFF_FFFF);
    expect_val("mtlo_busy_busy", 5, 32'd1);
    check_all();
    applyStimulus(1'b1, 4'b0010, 6'h18, 32'd3, 32'd3);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h20, 32'h0, 32'h0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    expect_val("divu0_done", 6, 32'd1);
    expect_val("divu0_hi", 3, 32'h1234_5678);
    expect_val("divu0_lo", 4, 32'hFFFF_FFFF);
    check_all();
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h13, 32'hAA, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h12, 32'h0, 32'h0);
    expect_val("mflo_aa", 0, 32'hAA);
    #1 check_all();

    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h1A, 32'd100, 32'd3);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h20, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    expect_val("abort_busy", 5, 32'd0);
    expect_val("abort_hi", 3, 32'd0);
    expect_val("abort_lo", 4, 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1)
        pulses++;
    end
    compare("abort_no_done", pulses, 32'd0);
    run_muldiv("mult_3x4", 6'h18, 32'd3, 32'd4, 32'd0, 32'd12);
`else
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h18, 32'd5, 32'd7);
    expect_val("mult_as_add", 0, 32'd12);
    #1 check_all();
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h1B, 32'd9, 32'd1);
    expect_val("divu_as_add", 0, 32'd10);
    expect_val("nomd_busy", 5, 32'd0);
    expect_val("nomd_done", 6, 32'd0);
    expect_val("nomd_hi", 3, 32'h1234);
    expect_val("nomd_lo", 4, 32'h5678);
    #1 check_all();
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h20, 32'h0, 32'h0);
`endif

    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 6'h11, 32'h7777, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 6'h20, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    expect_val("async_rst_hi", 3, 32'd0);
    expect_val("async_rst_lo", 4, 32'd0);
    expect_val("async_rst_busy", 5, 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
